// File: rtl/pong_game_logic.sv
// Pong game-state engine: paddles, ball, scoring and serve/play/game-over sequencing, advanced once per new_frame_i.
// Optional build macro PONG_TWO_PLAYER_EN: right paddle follows btn2_up_i/btn2_down_i instead of the tracking AI.
module pong_game_logic #(
  parameter int SCREEN_H_RES  = 640,
  parameter int SCREEN_V_RES  = 480,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int BALL_SIDE     = 8,
  parameter int BALL_SPEED    = 4,
  parameter int PADDLE_SPEED  = 6,
  parameter int PC_SPEED      = 3,
  parameter int PADDLE_MARGIN = 16,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 9,
  parameter int X_POS_W       = $clog2(SCREEN_H_RES),
  parameter int Y_POS_W       = $clog2(SCREEN_V_RES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               btn_up_i,
  input  logic               btn_down_i,
`ifdef PONG_TWO_PLAYER_EN
  input  logic               btn2_up_i,
  input  logic               btn2_down_i,
`endif
  output logic [X_POS_W-1:0] player_paddle_x_o,
  output logic [Y_POS_W-1:0] player_paddle_y_o,
  output logic [X_POS_W-1:0] pc_paddle_x_o,
  output logic [Y_POS_W-1:0] pc_paddle_y_o,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [3:0]         player_score_o,
  output logic [3:0]         pc_score_o,
  output logic               game_over_o
);

  localparam int XW1   = X_POS_W + 1;
  localparam int YW1   = Y_POS_W + 1;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [1:0] ST_SERVE  = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_SCORED = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [X_POS_W-1:0] BALL_X_C    = X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2);
  localparam logic [Y_POS_W-1:0] BALL_Y_C    = Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2);
  localparam logic [Y_POS_W-1:0] PAD_Y_C     = Y_POS_W'((SCREEN_V_RES - PADDLE_HEIGHT) / 2);
  localparam logic [X_POS_W-1:0] LEFT_PAD_X  = X_POS_W'(PADDLE_MARGIN);
  localparam logic [X_POS_W-1:0] RIGHT_PAD_X = X_POS_W'(SCREEN_H_RES - PADDLE_MARGIN - PADDLE_WIDTH);
  localparam logic [X_POS_W-1:0] LEFT_STOP   = X_POS_W'(PADDLE_MARGIN + PADDLE_WIDTH);
  localparam logic [X_POS_W-1:0] RIGHT_STOP  =
    X_POS_W'(SCREEN_H_RES - PADDLE_MARGIN - PADDLE_WIDTH - BALL_SIDE);
  localparam logic [Y_POS_W-1:0] BALL_Y_MAX  = Y_POS_W'(SCREEN_V_RES - BALL_SIDE);
  localparam logic [Y_POS_W-1:0] PAD_STEP    = Y_POS_W'(PADDLE_SPEED);
  localparam logic [CNT_W-1:0]   SERVE_LOAD  = CNT_W'(SERVE_FRAMES);
  localparam logic [3:0]         WIN         = 4'(WIN_SCORE);

  localparam logic signed [XW1-1:0] BSTEP_X      = XW1'(BALL_SPEED);
  localparam logic signed [YW1-1:0] BSTEP_Y      = YW1'(BALL_SPEED);
  localparam logic signed [XW1-1:0] BALL_X_MAX_S = XW1'(SCREEN_H_RES - BALL_SIDE);
  localparam logic signed [YW1-1:0] BALL_Y_MAX_S = YW1'(SCREEN_V_RES - BALL_SIDE);
  localparam logic signed [XW1-1:0] LEFT_STOP_S  = XW1'(PADDLE_MARGIN + PADDLE_WIDTH);
  localparam logic signed [XW1-1:0] RIGHT_STOP_S =
    XW1'(SCREEN_H_RES - PADDLE_MARGIN - PADDLE_WIDTH - BALL_SIDE);
  localparam logic signed [YW1-1:0] PAD_H_S      = YW1'(PADDLE_HEIGHT);
  localparam logic signed [YW1-1:0] BALL_SIDE_S  = YW1'(BALL_SIDE);
  localparam logic signed [YW1-1:0] PAD_Y_MAX_S  = YW1'(SCREEN_V_RES - PADDLE_HEIGHT);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   serveCnt_q, serveCnt_d;
  logic [Y_POS_W-1:0] playerY_q, playerY_d;
  logic [Y_POS_W-1:0] pcY_q, pcY_d;
  logic [X_POS_W-1:0] ballX_q, ballX_d;
  logic [Y_POS_W-1:0] ballY_q, ballY_d;
  logic               dxPos_q, dxPos_d;
  logic               dyPos_q, dyPos_d;
  logic [3:0]         playerScore_q, playerScore_d;
  logic [3:0]         pcScore_q, pcScore_d;
  logic               gameOver_q, gameOver_d;
  logic               pcScored_q, pcScored_d;

  logic signed [XW1-1:0] ballXS, nextX;
  logic signed [YW1-1:0] ballYS, nextY, playerYS, pcYS;
  logic                  leftOverlap, rightOverlap, hitLeft, hitRight;
  logic [Y_POS_W-1:0]    playerMove, pcMove;

  // One paddle step: opposing or idle requests hold, result clamped to the playfield without wrapping.
  function automatic logic [Y_POS_W-1:0] movePaddle(
    input logic [Y_POS_W-1:0] y,
    input logic               up,
    input logic               down,
    input logic [Y_POS_W-1:0] step
  );
    logic signed [YW1-1:0] ny;
    ny = $signed({1'b0, y});
    if (up && !down) begin
      ny = ny - $signed({1'b0, step});
    end else if (down && !up) begin
      ny = ny + $signed({1'b0, step});
    end
    if (ny < 0) begin
      ny = '0;
    end else if (ny > PAD_Y_MAX_S) begin
      ny = PAD_Y_MAX_S;
    end
    return ny[Y_POS_W-1:0];
  endfunction

  assign playerMove = movePaddle(playerY_q, btn_up_i, btn_down_i, PAD_STEP);

`ifdef PONG_TWO_PLAYER_EN
  assign pcMove = movePaddle(pcY_q, btn2_up_i, btn2_down_i, PAD_STEP);
`else
  localparam int YW2 = Y_POS_W + 2;
  localparam logic [Y_POS_W-1:0]    PC_STEP     = Y_POS_W'(PC_SPEED);
  localparam logic signed [YW2-1:0] PC_STEP_S   = YW2'(PC_SPEED);
  localparam logic signed [YW2-1:0] PAD_HALF_S  = YW2'(PADDLE_HEIGHT / 2);
  localparam logic signed [YW2-1:0] BALL_HALF_S = YW2'(BALL_SIDE / 2);

  // Positive gap means the ball centre is below the paddle centre, so the paddle steps down.
  logic signed [YW2-1:0] trackGap;
  assign trackGap = ($signed({2'b0, ballY_q}) + BALL_HALF_S) - ($signed({2'b0, pcY_q}) + PAD_HALF_S);
  assign pcMove   = movePaddle(pcY_q, trackGap <= -PC_STEP_S, trackGap >= PC_STEP_S, PC_STEP);
`endif

  assign ballXS   = $signed({1'b0, ballX_q});
  assign ballYS   = $signed({1'b0, ballY_q});
  assign playerYS = $signed({1'b0, playerY_q});
  assign pcYS     = $signed({1'b0, pcY_q});
  assign nextX    = ballXS + (dxPos_q ? BSTEP_X : -BSTEP_X);
  assign nextY    = ballYS + (dyPos_q ? BSTEP_Y : -BSTEP_Y);

  // Paddle hits only count when the ball crosses the paddle face this frame and overlaps it after the move.
  assign leftOverlap  = (nextY < playerYS + PAD_H_S) && (nextY + BALL_SIDE_S > playerYS);
  assign rightOverlap = (nextY < pcYS + PAD_H_S) && (nextY + BALL_SIDE_S > pcYS);
  assign hitLeft  = !dxPos_q && (ballXS >= LEFT_STOP_S) && (nextX < LEFT_STOP_S) && leftOverlap;
  assign hitRight = dxPos_q && (ballXS <= RIGHT_STOP_S) && (nextX > RIGHT_STOP_S) && rightOverlap;

  always_comb begin
    state_d       = state_q;
    serveCnt_d    = serveCnt_q;
    playerY_d     = playerY_q;
    pcY_d         = pcY_q;
    ballX_d       = ballX_q;
    ballY_d       = ballY_q;
    dxPos_d       = dxPos_q;
    dyPos_d       = dyPos_q;
    playerScore_d = playerScore_q;
    pcScore_d     = pcScore_q;
    gameOver_d    = gameOver_q;
    pcScored_d    = pcScored_q;

    if (new_frame_i) begin
      if (state_q != ST_OVER) begin
        playerY_d = playerMove;
        pcY_d     = pcMove;
      end

      case (state_q)
        ST_SERVE: begin
          ballX_d = BALL_X_C;
          ballY_d = BALL_Y_C;
          if (serveCnt_q <= CNT_W'(1)) begin
            serveCnt_d = '0;
            state_d    = ST_PLAY;
          end else begin
            serveCnt_d = serveCnt_q - CNT_W'(1);
          end
        end

        ST_PLAY: begin
          if (nextY < 0) begin
            ballY_d = '0;
            dyPos_d = 1'b1;
          end else if (nextY > BALL_Y_MAX_S) begin
            ballY_d = BALL_Y_MAX;
            dyPos_d = 1'b0;
          end else begin
            ballY_d = nextY[Y_POS_W-1:0];
          end

          // A miss leaves x where it was; the next frame recentres the ball.
          if (hitLeft) begin
            ballX_d = LEFT_STOP;
            dxPos_d = 1'b1;
          end else if (hitRight) begin
            ballX_d = RIGHT_STOP;
            dxPos_d = 1'b0;
          end else if (nextX < 0) begin
            pcScored_d = 1'b1;
            state_d    = ST_SCORED;
          end else if (nextX > BALL_X_MAX_S) begin
            pcScored_d = 1'b0;
            state_d    = ST_SCORED;
          end else begin
            ballX_d = nextX[X_POS_W-1:0];
          end
        end

        ST_SCORED: begin
          ballX_d    = BALL_X_C;
          ballY_d    = BALL_Y_C;
          serveCnt_d = SERVE_LOAD;
          state_d    = ST_SERVE;
          if (pcScored_q) begin
            pcScore_d = pcScore_q + 4'd1;
            dxPos_d   = 1'b0;
            if (pcScore_q + 4'd1 == WIN) begin
              state_d    = ST_OVER;
              gameOver_d = 1'b1;
            end
          end else begin
            playerScore_d = playerScore_q + 4'd1;
            dxPos_d       = 1'b1;
            if (playerScore_q + 4'd1 == WIN) begin
              state_d    = ST_OVER;
              gameOver_d = 1'b1;
            end
          end
        end

        default: begin
          ballX_d = BALL_X_C;
          ballY_d = BALL_Y_C;
          if (btn_up_i || btn_down_i) begin
            playerScore_d = '0;
            pcScore_d     = '0;
            gameOver_d    = 1'b0;
            serveCnt_d    = SERVE_LOAD;
            state_d       = ST_SERVE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_SERVE;
      serveCnt_q    <= SERVE_LOAD;
      playerY_q     <= PAD_Y_C;
      pcY_q         <= PAD_Y_C;
      ballX_q       <= BALL_X_C;
      ballY_q       <= BALL_Y_C;
      dxPos_q       <= 1'b1;
      dyPos_q       <= 1'b1;
      playerScore_q <= '0;
      pcScore_q     <= '0;
      gameOver_q    <= 1'b0;
      pcScored_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      serveCnt_q    <= serveCnt_d;
      playerY_q     <= playerY_d;
      pcY_q         <= pcY_d;
      ballX_q       <= ballX_d;
      ballY_q       <= ballY_d;
      dxPos_q       <= dxPos_d;
      dyPos_q       <= dyPos_d;
      playerScore_q <= playerScore_d;
      pcScore_q     <= pcScore_d;
      gameOver_q    <= gameOver_d;
      pcScored_q    <= pcScored_d;
    end
  end

  assign player_paddle_x_o = LEFT_PAD_X;
  assign pc_paddle_x_o     = RIGHT_PAD_X;
  assign player_paddle_y_o = playerY_q;
  assign pc_paddle_y_o     = pcY_q;
  assign ball_x_o          = ballX_q;
  assign ball_y_o          = ballY_q;
  assign player_score_o    = playerScore_q;
  assign pc_score_o        = pcScore_q;
  assign game_over_o       = gameOver_q;

endmodule

// File: tb/tb_pong_game_logic.sv
// Self-checking bench for pong_game_logic: directed vectors, serve/reset/clamp sequences and a random game
// compared frame by frame against a behavioural model of the game rules.
module tb_pong_game_logic;

  localparam int PAD_Y_RESET  = 210;
  localparam int BALL_X_RESET = 316;
  localparam int BALL_Y_RESET = 236;
  localparam int PH_SERVE  = 0;
  localparam int PH_PLAY   = 1;
  localparam int PH_SCORED = 2;
  localparam int PH_OVER   = 3;

  logic       clk_i;
  logic       rst_ni;
  logic       new_frame_i;
  logic       btn_up_i;
  logic       btn_down_i;
  logic [9:0] player_paddle_x_o;
  logic [8:0] player_paddle_y_o;
  logic [9:0] pc_paddle_x_o;
  logic [8:0] pc_paddle_y_o;
  logic [9:0] ball_x_o;
  logic [8:0] ball_y_o;
  logic [3:0] player_score_o;
  logic [3:0] pc_score_o;
  logic       game_over_o;

  int errors;
  int checks;

  // Model of the game in plain integers: positions, directions as +1/-1, phase and frames left to serve.
  int mPly, mPcy, mBx, mBy, mDx, mDy, mPs, mCs, mOver, mPhase, mServeLeft, mPcScored;

  typedef struct {
    bit up;
    bit dn;
    int ply;
    int pcy;
    int bx;
    int by;
  } vec_t;
  vec_t vecs[6];

  pong_game_logic dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .new_frame_i       (new_frame_i),
    .btn_up_i          (btn_up_i),
    .btn_down_i        (btn_down_i),
    .player_paddle_x_o (player_paddle_x_o),
    .player_paddle_y_o (player_paddle_y_o),
    .pc_paddle_x_o     (pc_paddle_x_o),
    .pc_paddle_y_o     (pc_paddle_y_o),
    .ball_x_o          (ball_x_o),
    .ball_y_o          (ball_y_o),
    .player_score_o    (player_score_o),
    .pc_score_o        (pc_score_o),
    .game_over_o       (game_over_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("player_x", int'(player_paddle_x_o), 16);
    checkVal("pc_x", int'(pc_paddle_x_o), 614);
    checkVal("player_y", int'(player_paddle_y_o), mPly);
    checkVal("pc_y", int'(pc_paddle_y_o), mPcy);
    checkVal("ball_x", int'(ball_x_o), mBx);
    checkVal("ball_y", int'(ball_y_o), mBy);
    checkVal("player_score", int'(player_score_o), mPs);
    checkVal("pc_score", int'(pc_score_o), mCs);
    checkVal("game_over", int'(game_over_o), mOver);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_player_y"}, int'(player_paddle_y_o), PAD_Y_RESET);
    checkVal({tag, "_pc_y"}, int'(pc_paddle_y_o), PAD_Y_RESET);
    checkVal({tag, "_ball_x"}, int'(ball_x_o), BALL_X_RESET);
    checkVal({tag, "_ball_y"}, int'(ball_y_o), BALL_Y_RESET);
    checkVal({tag, "_scores"}, int'(player_score_o) + int'(pc_score_o), 0);
    checkVal({tag, "_game_over"}, int'(game_over_o), 0);
  endtask

  task automatic modelReset();
    mPly = PAD_Y_RESET;  mPcy = PAD_Y_RESET;
    mBx = BALL_X_RESET;  mBy = BALL_Y_RESET;
    mDx = 1;  mDy = 1;
    mPs = 0;  mCs = 0;  mOver = 0;  mPcScored = 0;
    mPhase = PH_SERVE;  mServeLeft = 60;
  endtask

  // Advance the model by one frame; every rule reads the positions as they were before this frame.
  task automatic modelFrame(input bit up, input bit dn);
    int oldP;
    int oldC;
    int nx;
    int ny;
    int gap;
    oldP = mPly;
    oldC = mPcy;
    if (mPhase != PH_OVER) begin
      if (up && !dn) mPly = (oldP >= 6) ? oldP - 6 : 0;
      else if (dn && !up) mPly = (oldP + 6 <= 420) ? oldP + 6 : 420;
      gap = (mBy + 4) - (oldC + 30);
      if (gap >= 3) mPcy = (oldC + 3 <= 420) ? oldC + 3 : 420;
      else if (gap <= -3) mPcy = (oldC >= 3) ? oldC - 3 : 0;
    end
    case (mPhase)
      PH_SERVE: begin
        mBx = BALL_X_RESET;
        mBy = BALL_Y_RESET;
        mServeLeft--;
        if (mServeLeft == 0) mPhase = PH_PLAY;
      end
      PH_PLAY: begin
        nx = mBx + 4 * mDx;
        ny = mBy + 4 * mDy;
        if (ny < 0) begin
          mBy = 0;  mDy = 1;
        end else if (ny > 472) begin
          mBy = 472;  mDy = -1;
        end else begin
          mBy = ny;
        end
        if (mDx < 0 && mBx >= 26 && nx < 26 && ny < oldP + 60 && ny + 8 > oldP) begin
          mBx = 26;  mDx = 1;
        end else if (mDx > 0 && mBx + 8 <= 614 && nx + 8 > 614 && ny < oldC + 60 && ny + 8 > oldC) begin
          mBx = 606;  mDx = -1;
        end else if (nx < 0) begin
          mPcScored = 1;  mPhase = PH_SCORED;
        end else if (nx > 632) begin
          mPcScored = 0;  mPhase = PH_SCORED;
        end else begin
          mBx = nx;
        end
      end
      PH_SCORED: begin
        mBx = BALL_X_RESET;
        mBy = BALL_Y_RESET;
        if (mPcScored != 0) begin
          mCs++;  mDx = -1;
        end else begin
          mPs++;  mDx = 1;
        end
        if (mCs == 9 || mPs == 9) begin
          mPhase = PH_OVER;  mOver = 1;
        end else begin
          mPhase = PH_SERVE;  mServeLeft = 60;
        end
      end
      default: begin
        mBx = BALL_X_RESET;
        mBy = BALL_Y_RESET;
        if (up || dn) begin
          mPs = 0;  mCs = 0;  mOver = 0;
          mPhase = PH_SERVE;  mServeLeft = 60;
        end
      end
    endcase
  endtask

  // One frame pulse with the given buttons, then a gap cycle with random buttons that must change nothing.
  task automatic applyStimulus(input bit up, input bit dn);
    @(negedge clk_i);
    btn_up_i    = up;
    btn_down_i  = dn;
    new_frame_i = 1'b1;
    @(negedge clk_i);
    new_frame_i = 1'b0;
    modelFrame(up, dn);
    checkOutput();
    btn_up_i   = 1'($urandom_range(0, 1));
    btn_down_i = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit reached;
    errors      = 0;
    checks      = 0;
    rst_ni      = 1'b0;
    new_frame_i = 1'b0;
    btn_up_i    = 1'b0;
    btn_down_i  = 1'b0;
    modelReset();
    #12;
    checkResetValues("reset");
    checkOutput();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Serve phase: ball parked at centre, pc paddle already centred on it so it stays put.
    vecs[0] = '{up: 1'b1, dn: 1'b0, ply: 204, pcy: 210, bx: 316, by: 236};
    vecs[1] = '{up: 1'b1, dn: 1'b0, ply: 198, pcy: 210, bx: 316, by: 236};
    vecs[2] = '{up: 1'b1, dn: 1'b1, ply: 198, pcy: 210, bx: 316, by: 236};
    vecs[3] = '{up: 1'b0, dn: 1'b0, ply: 198, pcy: 210, bx: 316, by: 236};
    vecs[4] = '{up: 1'b0, dn: 1'b1, ply: 204, pcy: 210, bx: 316, by: 236};
    vecs[5] = '{up: 1'b0, dn: 1'b1, ply: 210, pcy: 210, bx: 316, by: 236};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].up, vecs[i].dn);
      checkVal($sformatf("vec%0d_player_y", i), int'(player_paddle_y_o), vecs[i].ply);
      checkVal($sformatf("vec%0d_pc_y", i), int'(pc_paddle_y_o), vecs[i].pcy);
      checkVal($sformatf("vec%0d_ball_x", i), int'(ball_x_o), vecs[i].bx);
      checkVal($sformatf("vec%0d_ball_y", i), int'(ball_y_o), vecs[i].by);
    end

    for (int f = 7; f <= 60; f++) begin
      applyStimulus(1'b0, 1'b0);
      checkVal($sformatf("serve_hold_x_f%0d", f), int'(ball_x_o), 316);
      checkVal($sformatf("serve_hold_y_f%0d", f), int'(ball_y_o), 236);
    end
    applyStimulus(1'b0, 1'b0);
    checkVal("first_move_x", int'(ball_x_o), 320);
    checkVal("first_move_y", int'(ball_y_o), 240);
    repeat (5) applyStimulus(1'b0, 1'b0);

    // Asynchronous reset between clock edges must restore everything at once.
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checkResetValues("async_reset");
    modelReset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    repeat (40) applyStimulus(1'b1, 1'b0);
    checkVal("clamp_top", int'(player_paddle_y_o), 0);
    repeat (80) applyStimulus(1'b0, 1'b1);
    checkVal("clamp_bottom", int'(player_paddle_y_o), 420);
    repeat (3) applyStimulus(1'b1, 1'b1);
    checkVal("both_pressed", int'(player_paddle_y_o), 420);

    reached = 1'b0;
    for (int f = 0; f < 15000 && !reached; f++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if (mOver != 0) reached = 1'b1;
    end
    checkVal("game_over_reached", int'(reached), 1);

    for (int f = 0; f < 5; f++) begin
      applyStimulus(1'b0, 1'b0);
      checkVal("over_flag", int'(game_over_o), 1);
      checkVal("over_ball_x", int'(ball_x_o), 316);
      checkVal("over_ball_y", int'(ball_y_o), 236);
      checkVal("over_winner", int'(player_score_o == 4'd9 || pc_score_o == 4'd9), 1);
    end
    applyStimulus(1'b0, 1'b1);
    checkVal("restart_player_score", int'(player_score_o), 0);
    checkVal("restart_pc_score", int'(pc_score_o), 0);
    checkVal("restart_game_over", int'(game_over_o), 0);

    repeat (300) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
